// File: rtl/mips_run_ctrl_pkg.sv
// mips_run_ctrl_pkg: shared state encoding and constants for the run controller
package mips_run_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if: CPU observation, start/golden inputs and run status of the run controller
interface mips_run_ctrl_if
   import mips_run_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = 16
) ();
   logic              start;
   logic [DATA_W-1:0] pc_in;
   logic              reg_write;
   logic [4:0]        write_reg;
   logic [DATA_W-1:0] write_data_reg;
   logic [DATA_W-1:0] expected_sig;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              halted;
   logic              timeout;
   logic              pass;
   logic [CNT_W-1:0]  cycle_count;
   logic [DATA_W-1:0] signature;
   modport master (
      output start, pc_in, reg_write, write_reg, write_data_reg, expected_sig,
      input  cpu_rst, busy, done, halted, timeout, pass, cycle_count, signature
   );
   modport slave (
      input  start, pc_in, reg_write, write_reg, write_data_reg, expected_sig,
      output cpu_rst, busy, done, halted, timeout, pass, cycle_count, signature
   );
endinterface

// File: rtl/mips_run_ctrl_sig_acc.sv
// mips_run_ctrl_sig_acc: write-back signature register, rotate-left-by-one then XOR data and register index
module mips_run_ctrl_sig_acc #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [4:0]        idx_i,
   output logic [DATA_W-1:0] sig_o
);
   logic [DATA_W-1:0] sig_q;
   always_ff @(posedge clk) begin
      if (rst || clr_i) sig_q <= '0;
      else if (en_i) sig_q <= {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ data_i ^ {{(DATA_W-5){1'b0}}, idx_i};
   end
   assign sig_o = sig_q;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: reset/run sequencer for MipsCPU with halt/timeout detection and write-back signature check
module mips_run_ctrl
   import mips_run_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int RST_CYCLES  = 1,
   parameter int MAX_CYCLES  = 10,
   parameter int HALT_REPEAT = 2,
   parameter int CNT_W       = 16
) (
   input logic           clk,
   input logic           rst,
   mips_run_ctrl_if.slave bus
);
   state_e            state_q;
   logic [CNT_W-1:0]  hcnt_q, cnt_q, same_q, cnt_d, same_d;
   logic [DATA_W-1:0] prev_pc_q;
   logic              pc_valid_q, cpu_rst_q, busy_q, done_q, halted_q, timeout_q;
   logic              go, halt_d, tmo_d, sig_en;
   always_comb begin
      go     = bus.start && (state_q == IDLE || state_q == DONE);
      cnt_d  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      same_d = (pc_valid_q && bus.pc_in == prev_pc_q) ? same_q + CNT_W'(1) : '0;
      halt_d = same_d >= CNT_W'(HALT_REPEAT);
      tmo_d  = cnt_d >= CNT_W'(MAX_CYCLES);
      sig_en = state_q == RUN && bus.reg_write && bus.write_reg != REG_ZERO;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cpu_rst_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
         hcnt_q     <= '0;
         cnt_q      <= '0;
         same_q     <= '0;
         prev_pc_q  <= '0;
         pc_valid_q <= 1'b0;
      end else if (go) begin
         state_q    <= HOLD;
         cpu_rst_q  <= 1'b1;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         halted_q   <= 1'b0;
         timeout_q  <= 1'b0;
         hcnt_q     <= '0;
         cnt_q      <= '0;
         same_q     <= '0;
         pc_valid_q <= 1'b0;
      end else if (state_q == HOLD) begin
         if (hcnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_q   <= RUN;
            cpu_rst_q <= 1'b0;
         end else hcnt_q <= hcnt_q + CNT_W'(1);
      end else if (state_q == RUN) begin
         cnt_q      <= cnt_d;
         same_q     <= same_d;
         prev_pc_q  <= bus.pc_in;
         pc_valid_q <= 1'b1;
         // halt takes priority when both end conditions land on the same cycle
         if (halt_d || tmo_d) begin
            state_q   <= DONE;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            halted_q  <= halt_d;
            timeout_q <= !halt_d;
         end
      end
   end
   mips_run_ctrl_sig_acc #(.DATA_W(DATA_W)) u_sig (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (go),
      .en_i   (sig_en),
      .data_i (bus.write_data_reg),
      .idx_i  (bus.write_reg),
      .sig_o  (bus.signature)
   );
   assign bus.cpu_rst     = cpu_rst_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.halted      = halted_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cnt_q;
   assign bus.pass        = done_q & halted_q & (bus.signature == bus.expected_sig);
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: directed checks of hold timing, halt, timeout, signature, halt priority and mid-run reset
module tb_mips_run_ctrl;
   logic clk, rst;
   int   n_chk = 0, n_err = 0;
   mips_run_ctrl_if #(.DATA_W(32), .CNT_W(16)) bus ();
   mips_run_ctrl #(
      .DATA_W(32), .RST_CYCLES(3), .MAX_CYCLES(10), .HALT_REPEAT(2), .CNT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic cyc(input logic [31:0] pc, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      bus.pc_in = pc;
      bus.reg_write = we;
      bus.write_reg = wr;
      bus.write_data_reg = wd;
      tick();
      bus.reg_write = 1'b0;
   endtask
   task automatic start_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
   endtask
   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.pc_in = '0;
      bus.reg_write = 1'b0;
      bus.write_reg = '0;
      bus.write_data_reg = '0;
      bus.expected_sig = 32'h9;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_cpu_rst", bus.cpu_rst, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_count", bus.cycle_count, 0);
      chk("rst_sig", bus.signature, 0);
      chk("rst_pass", bus.pass, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_cpu_rst", bus.cpu_rst, 1);
         chk("hold_busy", bus.busy, 1);
         tick();
      end
      chk("run_cpu_rst", bus.cpu_rst, 0);
      chk("run_busy", bus.busy, 1);
      // halt run: PC 0,4,8,8,8 with writes $1=5, $0=ff, $2=3
      cyc(32'd0, 1'b1, 5'd1, 32'h5);
      chk("sig_w1", bus.signature, 32'h4);
      cyc(32'd4, 1'b1, 5'd0, 32'hff);
      chk("sig_r0_ignored", bus.signature, 32'h4);
      chk("count_2", bus.cycle_count, 2);
      bus.start = 1'b1;
      cyc(32'd8, 1'b1, 5'd2, 32'h3);
      bus.start = 1'b0;
      chk("start_in_run_count", bus.cycle_count, 3);
      chk("start_in_run_busy", bus.busy, 1);
      chk("start_in_run_cpu_rst", bus.cpu_rst, 0);
      chk("sig_w2", bus.signature, 32'h9);
      cyc(32'd8, 1'b0, 5'd0, 32'h0);
      chk("halt_not_yet", bus.done, 0);
      cyc(32'd8, 1'b0, 5'd0, 32'h0);
      chk("halt_done", bus.done, 1);
      chk("halt_halted", bus.halted, 1);
      chk("halt_timeout", bus.timeout, 0);
      chk("halt_count", bus.cycle_count, 5);
      chk("halt_busy", bus.busy, 0);
      chk("halt_cpu_rst", bus.cpu_rst, 1);
      chk("halt_pass_9", bus.pass, 1);
      bus.expected_sig = 32'h8;
      #1;
      chk("halt_pass_8", bus.pass, 0);
      tick();
      chk("done_hold_count", bus.cycle_count, 5);
      chk("done_hold_sig", bus.signature, 32'h9);
      chk("done_hold_done", bus.done, 1);
      // timeout run: strictly incrementing PC
      bus.expected_sig = 32'h0;
      start_run();
      chk("restart_sig_clr", bus.signature, 0);
      chk("restart_done_clr", bus.done, 0);
      for (int i = 0; i < 9; i++) cyc(32'(i * 4), 1'b0, 5'd0, 32'h0);
      chk("tmo_not_yet", bus.done, 0);
      cyc(32'd36, 1'b0, 5'd0, 32'h0);
      chk("tmo_done", bus.done, 1);
      chk("tmo_timeout", bus.timeout, 1);
      chk("tmo_halted", bus.halted, 0);
      chk("tmo_count", bus.cycle_count, 10);
      chk("tmo_pass", bus.pass, 0);
      // self-loop completes exactly on cycle MAX_CYCLES
      start_run();
      for (int i = 0; i < 8; i++) cyc(32'(i * 4), 1'b0, 5'd0, 32'h0);
      cyc(32'd28, 1'b0, 5'd0, 32'h0);
      cyc(32'd28, 1'b0, 5'd0, 32'h0);
      chk("prio_done", bus.done, 1);
      chk("prio_halted", bus.halted, 1);
      chk("prio_timeout", bus.timeout, 0);
      chk("prio_count", bus.cycle_count, 10);
      chk("prio_pass", bus.pass, 1);
      // reset in RUN cycle 4
      start_run();
      cyc(32'd0, 1'b1, 5'd3, 32'h10);
      cyc(32'd4, 1'b0, 5'd0, 32'h0);
      cyc(32'd8, 1'b0, 5'd0, 32'h0);
      chk("mid_count", bus.cycle_count, 3);
      chk("mid_sig", bus.signature, 32'h13);
      bus.pc_in = 32'd12;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cpu_rst", bus.cpu_rst, 1);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_count", bus.cycle_count, 0);
      chk("mid_rst_sig", bus.signature, 0);
      chk("mid_rst_halted", bus.halted, 0);
      tick();
      chk("idle_stays_cpu_rst", bus.cpu_rst, 1);
      chk("idle_stays_busy", bus.busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
